// File: rtl/mul_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mul_arb
//  Description : Shares the two-stage AVR multiplier between the core MUL path
//                and an auxiliary coprocessor port (aux port enabled by the
//                MUL_ARB_AUX_EN macro).
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_arb #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        cp2,
    input  logic        ireset,
    input  logic        cp2en,
    input  logic        core_req,
    input  logic [2:0]  core_op,
    input  logic [7:0]  core_rd,
    input  logic [7:0]  core_rr,
    output logic        core_stall,
    output logic        core_done,
    output logic [15:0] core_res,
    output logic        core_c,
    output logic        core_z,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [2:0]  aux_op,
    input  logic [7:0]  aux_rd,
    input  logic [7:0]  aux_rr,
    output logic        aux_rsp_valid,
    input  logic        aux_rsp_ready,
    output logic [15:0] aux_res,
    output logic        aux_c,
    output logic        aux_z,
    output logic        mul_en,
    output logic        mul_fmul,
    output logic        mul_muls,
    output logic        mul_mulsu,
    output logic [7:0]  mul_rd,
    output logic [7:0]  mul_rr,
    input  logic [15:0] mr_in,
    input  logic        mc_in,
    input  logic        mz_in
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic c_OWNER_CORE = 1'b0;
    localparam logic c_OWNER_AUX  = 1'b1;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_owner;
    logic [2:0]  r_op;
    logic [7:0]  r_rd;
    logic [7:0]  r_rr;
    logic [15:0] r_core_res;
    logic        r_core_c;
    logic        r_core_z;

    logic        w_grant_core;
    logic        w_grant_aux;
    logic        w_aux_take;
    logic [2:0]  w_sel_op;
    logic [7:0]  w_sel_rd;
    logic [7:0]  w_sel_rr;

`ifdef MUL_ARB_AUX_EN
    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  r_starve;
    logic        r_aux_rsp_valid;
    logic [15:0] r_aux_res;
    logic        r_aux_c;
    logic        r_aux_z;

    // Aux is held off while the core is pending, unless aux has been starved.
    assign aux_ready = ireset && cp2en && (r_state == ST_IDLE) && !r_aux_rsp_valid
                       && !(core_req && (r_starve < c_STARVE_LIMIT));
    assign w_aux_take = aux_valid && aux_ready;

    assign w_sel_op = w_grant_aux ? aux_op : core_op;
    assign w_sel_rd = w_grant_aux ? aux_rd : core_rd;
    assign w_sel_rr = w_grant_aux ? aux_rr : core_rr;

    assign aux_rsp_valid = r_aux_rsp_valid;
    assign aux_res       = r_aux_res;
    assign aux_c         = r_aux_c;
    assign aux_z         = r_aux_z;

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            r_starve        <= 4'd0;
            r_aux_rsp_valid <= 1'b0;
            r_aux_res       <= 16'h0000;
            r_aux_c         <= 1'b0;
            r_aux_z         <= 1'b0;
        end else if (cp2en) begin
            if (r_state == ST_CAPTURE && r_owner == c_OWNER_AUX) begin
                r_aux_rsp_valid <= 1'b1;
                r_aux_res       <= mr_in;
                r_aux_c         <= mc_in;
                r_aux_z         <= mz_in;
            end else if (r_aux_rsp_valid && aux_rsp_ready) begin
                r_aux_rsp_valid <= 1'b0;
            end

            if (!aux_valid || w_grant_aux) begin
                r_starve <= 4'd0;
            end else if (w_grant_core && (r_starve < c_STARVE_LIMIT)) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end
`else
    logic w_aux_unused;

    assign w_aux_unused  = ^{aux_valid, aux_op, aux_rd, aux_rr, aux_rsp_ready};
    assign aux_ready     = 1'b0;
    assign w_aux_take    = 1'b0;
    assign w_sel_op      = core_op;
    assign w_sel_rd      = core_rd;
    assign w_sel_rr      = core_rr;
    assign aux_rsp_valid = 1'b0;
    assign aux_res       = 16'h0000;
    assign aux_c         = 1'b0;
    assign aux_z         = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_grant_core = 1'b0;
        w_grant_aux  = 1'b0;
        mul_en       = 1'b0;
        core_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_aux_take) begin
                    w_grant_aux = 1'b1;
                end else if (core_req && cp2en) begin
                    w_grant_core = 1'b1;
                end
                if (w_grant_aux || w_grant_core) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mul_en       = cp2en;
                w_next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                core_done    = cp2en && (r_owner == c_OWNER_CORE);
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            r_state    <= ST_IDLE;
            r_owner    <= c_OWNER_CORE;
            r_op       <= 3'b000;
            r_rd       <= 8'h00;
            r_rr       <= 8'h00;
            r_core_res <= 16'h0000;
            r_core_c   <= 1'b0;
            r_core_z   <= 1'b0;
        end else if (cp2en) begin
            r_state <= w_next_state;
            if (w_grant_core || w_grant_aux) begin
                r_owner <= w_grant_aux ? c_OWNER_AUX : c_OWNER_CORE;
                r_op    <= w_sel_op;
                r_rd    <= w_sel_rd;
                r_rr    <= w_sel_rr;
            end
            if (r_state == ST_CAPTURE && r_owner == c_OWNER_CORE) begin
                r_core_res <= mr_in;
                r_core_c   <= mc_in;
                r_core_z   <= mz_in;
            end
        end
    end

    // Mode stays asserted through CAPTURE: the multiplier's fmul shift is combinational.
    assign mul_fmul  = r_op[2];
    assign mul_muls  = r_op[1];
    assign mul_mulsu = r_op[0];
    assign mul_rd    = r_rd;
    assign mul_rr    = r_rr;

    // The product is presented live during the done cycle and held afterwards.
    assign core_res   = core_done ? mr_in : r_core_res;
    assign core_c     = core_done ? mc_in : r_core_c;
    assign core_z     = core_done ? mz_in : r_core_z;
    assign core_stall = core_req && !core_done;

endmodule
`default_nettype wire
